graph_frame_ctrl: RTL and testbench
===================================

Name: graph_frame_ctrl

Overview:
- Owns the point-coordinate and path register banks feeding the graph renderer.
- Generates the renderer's 256x256 pixel scan position.
- Double-buffers updates from the path solver: the solver writes a shadow bank through a valid/ready port, then requests a commit.
- The shadow bank is copied to the active bank only at a frame boundary, so the renderer never draws a half-updated path.

Parameters:
- N_PTS, 64, number of points and path entries.
- COORD_W, 8, coordinate width; also the width of pix_x and pix_y.
- IDX_W, 6, path index width; N_PTS must equal 2**IDX_W.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- scan_en  in  1  advance scan position this cycle
- wr_valid  in  1  shadow write request
- wr_ready  out  1  shadow write accepted when high together with wr_valid
- wr_kind  in  2  0=xs, 1=ys, 2=path, 3=illegal
- wr_addr  in  IDX_W  entry index
- wr_data  in  COORD_W  data; path writes use the low IDX_W bits
- commit_valid  in  1  request shadow-to-active swap
- commit_ready  out  1  commit accepted when high together with commit_valid
- commit_done  out  1  one-cycle pulse on the cycle after the swap
- pix_x  out  COORD_W  scan column (cnt low byte)
- pix_y  out  COORD_W  scan row (cnt high byte)
- frame_start  out  1  high while pix_x==0 and pix_y==0
- xs_o  out  N_PTS*COORD_W  active x bank
- ys_o  out  N_PTS*COORD_W  active y bank
- path_o  out  N_PTS*IDX_W  active path bank
- err  out  1  sticky flag, set by a wr_kind==3 write

Behaviour:
- Reset (rst low, asynchronous):
  - cnt=0; state=ACCEPT; err=0; commit_done=0.
  - xs and ys in both banks = 0.
  - path[i]=i in both banks (identity tour).
- Scan counter:
  - cnt is 2*COORD_W bits and increments by 1 on each cycle with scan_en=1.
  - Wraps from all-ones to 0.
  - Frame end (fe) = scan_en=1 and cnt==all-ones.
- FSM states: ACCEPT, PENDING, DONE.
- ACCEPT:
  - wr_ready=1 and commit_ready=1.
  - A write handshake updates shadow[wr_kind][wr_addr] at the clock edge.
  - A commit handshake moves the FSM to PENDING.
  - Write and commit in the same cycle: the write lands first, and the commit includes it.
- PENDING:
  - wr_ready=0 and commit_ready=0; the shadow bank is frozen.
  - On fe: active<=shadow (all three banks in one edge), cnt wraps to 0, FSM goes to DONE.
- DONE:
  - Held for one cycle: commit_done=1, wr_ready=0, commit_ready=0.
  - Then returns to ACCEPT.
- Shadow contents are kept after a swap, so the solver can make incremental edits.
- Illegal write (wr_kind==3): the handshake completes, no bank changes, err<=1. err is cleared only by reset.
- scan_en=0 while PENDING: the swap stalls indefinitely; no timeout.
- Active banks change only at the swap edge (or at reset), so a displayed frame always comes from a single commit.
- Reset mid-PENDING: the commit is abandoned, the banks return to reset values, and no commit_done pulse is produced.
- All outputs are registered except wr_ready, commit_ready and frame_start, which decode from state and cnt.

Optional Feature:
- Macro: GRAPH_CTRL_IMMEDIATE_EN.
- Defined:
  - A commit handshake in ACCEPT copies shadow to active on the same clock edge and goes directly to DONE.
  - PENDING is unreachable, and tearing is permitted.
  - A write in the same cycle as the commit is still included in the copy.
- Undefined: frame-boundary swap as described in Behaviour.

Decomposition:
- Package graph_pkg:
  - Constants N_PTS, COORD_W, IDX_W.
  - typedef coord_t (COORD_W bits).
  - typedef idx_t (IDX_W bits).
  - enum wr_kind_e {WK_XS, WK_YS, WK_PATH, WK_BAD}.
  - enum ctrl_state_e {ACCEPT, PENDING, DONE}.
- One sub-module: graph_scan_cnt.
  - Contents: cnt register, scan_en increment, pix_x/pix_y split, frame_start and fe decode.
  - Shared with any future renderer variant.

Test Plan:
- Reset: sample after rst release -> path_o entry 5 == 5, xs_o all 0, pix_x=pix_y=0, frame_start=1, wr_ready=1, commit_ready=1, err=0.
- Frame-boundary swap:
  - Stimulus: write xs[3]=0x40, then commit while cnt=0x1000, scan_en held high.
  - Expected: xs_o entry 3 stays 0 until the edge where cnt wraps 0xFFFF->0, then reads 0x40.
  - Expected: commit_done pulses for exactly one cycle, and wr_ready=0 throughout PENDING.
- Stalled scan: commit with scan_en=0 for 1000 cycles -> FSM stays PENDING, active banks unchanged, no commit_done; raising scan_en completes the swap at the next wrap.
- Same-cycle write and commit: write path[0]=7 with commit_valid in the same cycle -> after the swap, path_o entry 0 == 7.
- Illegal write: wr_kind=3 write -> wr_ready handshake completes, banks unchanged, err=1 and stays 1 after a later commit.
- Reset during PENDING: assert rst 50 cycles into PENDING -> state returns to ACCEPT, banks at reset values, no commit_done; repeat the second scenario with GRAPH_CTRL_IMMEDIATE_EN defined -> xs_o entry 3 == 0x40 one edge after the commit handshake.

Source files
------------

// File: rtl/graph_pkg.sv
// Shared constants, types and state encodings for the graph frame controller.
// Optional build macro used by this slice: GRAPH_CTRL_IMMEDIATE_EN.
package graph_pkg;

    localparam int unsigned N_PTS   = 64;
    localparam int unsigned COORD_W = 8;
    localparam int unsigned IDX_W   = 6;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [IDX_W-1:0]   idx_t;

    // Which shadow bank a solver write targets
    typedef enum logic [1:0] {
        WK_XS   = 2'd0,
        WK_YS   = 2'd1,
        WK_PATH = 2'd2,
        WK_BAD  = 2'd3
    } wr_kind_e;

    // Commit handshake state
    typedef enum logic [1:0] {
        ACCEPT  = 2'd0,
        PENDING = 2'd1,
        DONE    = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/graph_scan_cnt.sv
// Renderer scan position: a 2*COORD_W counter split into column/row,
// with frame-start and frame-end decodes.
module graph_scan_cnt #(
    parameter int unsigned COORD_W = graph_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scan_en,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               frame_start,
    output logic               fe
);

    logic [2*COORD_W-1:0] r_cnt;

    // Advance the scan position when enabled; wraps naturally from all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (scan_en) begin
            r_cnt <= r_cnt + (2*COORD_W)'(1);
        end
    end

    assign pix_x       = r_cnt[COORD_W-1:0];
    assign pix_y       = r_cnt[2*COORD_W-1:COORD_W];
    assign frame_start = (r_cnt == '0);
    assign fe          = scan_en && (r_cnt == '1);

endmodule

// File: rtl/graph_frame_ctrl.sv
// Point/path register banks for the graph renderer, double-buffered.
// The solver fills a shadow bank through a valid/ready port and then commits;
// the copy to the active bank normally waits for the frame end so a frame is
// never drawn from a half-updated path.
// Build macro GRAPH_CTRL_IMMEDIATE_EN: commit copies on the handshake edge.
module graph_frame_ctrl #(
    parameter int unsigned N_PTS   = graph_pkg::N_PTS,
    parameter int unsigned COORD_W = graph_pkg::COORD_W,
    parameter int unsigned IDX_W   = graph_pkg::IDX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scan_en,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [1:0]               wr_kind,
    input  logic [IDX_W-1:0]         wr_addr,
    input  logic [COORD_W-1:0]       wr_data,
    input  logic                     commit_valid,
    output logic                     commit_ready,
    output logic                     commit_done,
    output logic [COORD_W-1:0]       pix_x,
    output logic [COORD_W-1:0]       pix_y,
    output logic                     frame_start,
    output logic [N_PTS*COORD_W-1:0] xs_o,
    output logic [N_PTS*COORD_W-1:0] ys_o,
    output logic [N_PTS*IDX_W-1:0]   path_o,
    output logic                     err
);

    import graph_pkg::*;

    ctrl_state_e r_state, w_state_nxt;

    logic [COORD_W-1:0] r_xs_sh [N_PTS];
    logic [COORD_W-1:0] r_ys_sh [N_PTS];
    logic [IDX_W-1:0]   r_pa_sh [N_PTS];
    logic [COORD_W-1:0] r_xs_ac [N_PTS];
    logic [COORD_W-1:0] r_ys_ac [N_PTS];
    logic [IDX_W-1:0]   r_pa_ac [N_PTS];

    logic r_err;
    logic r_commit_done;
    logic w_fe;
    logic w_wr_fire;
    logic w_cm_fire;
    logic w_swap;

    graph_scan_cnt #(.COORD_W(COORD_W)) u_scan (
        .clk         (clk),
        .rst         (rst),
        .scan_en     (scan_en),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .fe          (w_fe)
    );

    assign w_wr_fire = wr_valid && wr_ready;
    assign w_cm_fire = commit_valid && commit_ready;

`ifdef GRAPH_CTRL_IMMEDIATE_EN
    assign w_swap = (r_state == ACCEPT) && w_cm_fire;
`else
    assign w_swap = (r_state == PENDING) && w_fe;
`endif

    // Next-state and handshake-ready decode
    always_comb begin
        w_state_nxt  = r_state;
        wr_ready     = 1'b0;
        commit_ready = 1'b0;
        case (r_state)
            ACCEPT: begin
                wr_ready     = 1'b1;
                commit_ready = 1'b1;
                if (commit_valid) begin
`ifdef GRAPH_CTRL_IMMEDIATE_EN
                    w_state_nxt = DONE;
`else
                    w_state_nxt = PENDING;
`endif
                end
            end
            PENDING: if (w_fe) w_state_nxt = DONE;
            DONE:    w_state_nxt = ACCEPT;
            default: w_state_nxt = ACCEPT;
        endcase
    end

    // State register plus registered commit_done and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ACCEPT;
            r_commit_done <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_commit_done <= (w_state_nxt == DONE);
            if (w_wr_fire && (wr_kind == WK_BAD)) r_err <= 1'b1;
        end
    end

    // Shadow bank: solver writes land here; illegal kinds change nothing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_PTS; i++) begin
                r_xs_sh[IDX_W'(i)] <= '0;
                r_ys_sh[IDX_W'(i)] <= '0;
                r_pa_sh[IDX_W'(i)] <= IDX_W'(i);
            end
        end else if (w_wr_fire) begin
            case (wr_kind)
                WK_XS:   r_xs_sh[wr_addr] <= wr_data;
                WK_YS:   r_ys_sh[wr_addr] <= wr_data;
                WK_PATH: r_pa_sh[wr_addr] <= wr_data[IDX_W-1:0];
                default: ;
            endcase
        end
    end

    // Active bank: whole-bank copy on the swap edge; a write accepted on that
    // same edge is forwarded so the copy includes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_PTS; i++) begin
                r_xs_ac[IDX_W'(i)] <= '0;
                r_ys_ac[IDX_W'(i)] <= '0;
                r_pa_ac[IDX_W'(i)] <= IDX_W'(i);
            end
        end else if (w_swap) begin
            for (int unsigned i = 0; i < N_PTS; i++) begin
                r_xs_ac[IDX_W'(i)] <= (w_wr_fire && wr_kind == WK_XS && wr_addr == IDX_W'(i))
                                      ? wr_data : r_xs_sh[IDX_W'(i)];
                r_ys_ac[IDX_W'(i)] <= (w_wr_fire && wr_kind == WK_YS && wr_addr == IDX_W'(i))
                                      ? wr_data : r_ys_sh[IDX_W'(i)];
                r_pa_ac[IDX_W'(i)] <= (w_wr_fire && wr_kind == WK_PATH && wr_addr == IDX_W'(i))
                                      ? wr_data[IDX_W-1:0] : r_pa_sh[IDX_W'(i)];
            end
        end
    end

    // Flatten the active banks onto the renderer buses
    always_comb begin
        xs_o   = '0;
        ys_o   = '0;
        path_o = '0;
        for (int unsigned i = 0; i < N_PTS; i++) begin
            xs_o[i*COORD_W +: COORD_W] = r_xs_ac[IDX_W'(i)];
            ys_o[i*COORD_W +: COORD_W] = r_ys_ac[IDX_W'(i)];
            path_o[i*IDX_W +: IDX_W]   = r_pa_ac[IDX_W'(i)];
        end
    end

    assign commit_done = r_commit_done;
    assign err         = r_err;

endmodule

// File: tb/tb_graph_frame_ctrl.sv
// Directed-plus-random bench for graph_frame_ctrl against a behavioural model
// of the double-buffered banks and the scan position.
module tb_graph_frame_ctrl;
    import graph_pkg::*;

    localparam int unsigned N  = N_PTS;
    localparam int unsigned CW = COORD_W;
    localparam int unsigned IW = IDX_W;
    localparam int unsigned W  = N * CW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, scan_en, wr_valid, commit_valid;
    logic [1:0]      wr_kind;
    logic [IW-1:0]   wr_addr;
    logic [CW-1:0]   wr_data;
    logic            wr_ready, commit_ready, commit_done, frame_start, err;
    logic [CW-1:0]   pix_x, pix_y;
    logic [N*CW-1:0] xs_o, ys_o;
    logic [N*IW-1:0] path_o;

    graph_frame_ctrl #(.N_PTS(N), .COORD_W(CW), .IDX_W(IW)) u_dut (
        .clk(clk), .rst(rst), .scan_en(scan_en),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_kind(wr_kind),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_done(commit_done), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .xs_o(xs_o), .ys_o(ys_o),
        .path_o(path_o), .err(err)
    );

    // Reference model: frame position as a plain number, banks as arrays
    int unsigned   m_pos;
    bit            m_pend, m_done, m_err;
    logic [CW-1:0] m_xs_sh [N], m_ys_sh [N], m_xs_ac [N], m_ys_ac [N];
    logic [IW-1:0] m_pa_sh [N], m_pa_ac [N];

    int n_vec = 0;
    int n_err = 0;
    int n_done_seen = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_pend = 0; m_done = 0; m_err = 0;
        for (int i = 0; i < N; i++) begin
            m_xs_sh[i] = '0; m_ys_sh[i] = '0; m_pa_sh[i] = IW'(i);
            m_xs_ac[i] = '0; m_ys_ac[i] = '0; m_pa_ac[i] = IW'(i);
        end
    endtask

    task automatic model_copy();
        for (int i = 0; i < N; i++) begin
            m_xs_ac[i] = m_xs_sh[i]; m_ys_ac[i] = m_ys_sh[i]; m_pa_ac[i] = m_pa_sh[i];
        end
    endtask

    // One clock edge of the specified behaviour, using the current inputs
    task automatic model_edge();
        bit rdy, wf, cf, fend, nd;
        rdy  = !m_pend && !m_done;
        wf   = wr_valid && rdy;
        cf   = commit_valid && rdy;
        fend = scan_en && (m_pos == 65535);
        nd   = 0;
        if (wf) begin
            case (wr_kind)
                2'd0: m_xs_sh[wr_addr] = wr_data;
                2'd1: m_ys_sh[wr_addr] = wr_data;
                2'd2: m_pa_sh[wr_addr] = wr_data[IW-1:0];
                default: m_err = 1;
            endcase
        end
`ifdef GRAPH_CTRL_IMMEDIATE_EN
        if (cf) begin model_copy(); nd = 1; end
`else
        if (m_pend && fend) begin model_copy(); nd = 1; end
        m_pend = (m_pend && !fend) || cf;
`endif
        m_done = nd;
        if (scan_en) m_pos = (m_pos + 1) % 65536;
    endtask

    task automatic check_all();
        logic [N*CW-1:0] ex, ey;
        logic [N*IW-1:0] ep;
        for (int i = 0; i < N; i++) begin
            ex[i*CW +: CW] = m_xs_ac[i];
            ey[i*CW +: CW] = m_ys_ac[i];
            ep[i*IW +: IW] = m_pa_ac[i];
        end
        n_vec++;
        if (commit_done === 1'b1) n_done_seen++;
        chk("pix_x",        W'(pix_x),        W'(m_pos % 256));
        chk("pix_y",        W'(pix_y),        W'(m_pos / 256));
        chk("frame_start",  W'(frame_start),  W'(m_pos == 0));
        chk("wr_ready",     W'(wr_ready),     W'(!m_pend && !m_done));
        chk("commit_ready", W'(commit_ready), W'(!m_pend && !m_done));
        chk("commit_done",  W'(commit_done),  W'(m_done));
        chk("err",          W'(err),          W'(m_err));
        chk("xs_o",         W'(xs_o),         W'(ex));
        chk("ys_o",         W'(ys_o),         W'(ey));
        chk("path_o",       W'(path_o),       W'(ep));
    endtask

    // Inputs are already applied at the falling edge; check, clock, model
    task automatic step();
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic rand_write(input bit allow_bad);
        wr_valid = 1'($urandom_range(0, 1));
        wr_kind  = allow_bad ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
        wr_addr  = IW'($urandom);
        wr_data  = CW'($urandom);
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; scan_en = 1'b0; wr_valid = 1'b0; commit_valid = 1'b0;
        wr_kind = '0; wr_addr = '0; wr_data = '0;
        model_reset();
        @(negedge clk);
        async_reset();

        // Reset state
        chk("rst_path5",  W'(path_o[5*IW +: IW]), W'(5));
        chk("rst_xs",     W'(xs_o), '0);
        chk("rst_fs",     W'(frame_start), W'(1));
        chk("rst_wr_rdy", W'(wr_ready), W'(1));
        chk("rst_err",    W'(err), W'(0));

        // Illegal write completes but touches no bank
        wr_valid = 1'b1; wr_kind = 2'd3; wr_addr = 6'd9; wr_data = 8'hA5;
        step();
        wr_valid = 1'b0;
        chk("bad_err", W'(err), W'(1));
        chk("bad_xs",  W'(xs_o), '0);

        // Reset 50 cycles into PENDING abandons the commit
        wr_valid = 1'b1; wr_kind = 2'd0; wr_addr = 6'd3; wr_data = 8'h40;
        step();
        wr_valid = 1'b0; commit_valid = 1'b1; scan_en = 1'b1;
        step();
        commit_valid = 1'b0;
        n_done_seen = 0;
        for (int k = 0; k < 50; k++) begin rand_write(1'b1); step(); end
        wr_valid = 1'b0;
        async_reset();
        chk("prst_ready", W'(commit_ready), W'(1));
        chk("prst_xs3",   W'(xs_o[3*CW +: CW]), W'(0));
        for (int k = 0; k < 8; k++) step();
        chk("prst_nodone", W'(n_done_seen), W'(0));

        // Random shadow traffic with a random scan; active must not move
        for (int k = 0; k < 200; k++) begin
            rand_write(1'b1);
            scan_en = 1'($urandom_range(0, 1));
            step();
        end
        wr_valid = 1'b1; wr_kind = 2'd0; wr_addr = 6'd3; wr_data = 8'h40;
        step();
        wr_valid = 1'b1; wr_kind = 2'd3; wr_addr = 6'd0; wr_data = 8'h00;
        step();
        wr_valid = 1'b0; scan_en = 1'b1;
        for (int k = 0; k < 5000 && m_pos != 32'h1000; k++) step();
        chk("pos_1000", W'({pix_y, pix_x}), W'(16'h1000));

        // Commit at 0x1000 with a same-cycle path[0]=7 write
        wr_valid = 1'b1; wr_kind = 2'd2; wr_addr = 6'd0; wr_data = 8'd7;
        commit_valid = 1'b1;
        n_done_seen = 0;
        step();
        commit_valid = 1'b0;

        // Writes offered while the commit is pending must be refused
        for (int k = 0; k < 40000 && m_pos != 32'h8000; k++) begin
            rand_write(1'b0);
            if (!m_done) chk("hold_xs3", W'(xs_o[3*CW +: CW]), W'(0));
            step();
        end
        scan_en = 1'b0;
        for (int k = 0; k < 1000; k++) begin rand_write(1'b0); step(); end
        chk("stall_nodone", W'(n_done_seen), W'(0));
        scan_en = 1'b1;
        for (int k = 0; k < 70000 && !m_done; k++) begin
            rand_write(1'b0);
            if (!m_done) chk("hold_xs3", W'(xs_o[3*CW +: CW]), W'(0));
            step();
        end
        wr_valid = 1'b0;
        chk("swap_done",  W'(commit_done), W'(1));
        chk("swap_xs3",   W'(xs_o[3*CW +: CW]), W'(8'h40));
        chk("swap_path0", W'(path_o[0 +: IW]), W'(7));
        chk("swap_err",   W'(err), W'(1));
        for (int k = 0; k < 4; k++) step();
        chk("done_once",  W'(n_done_seen), W'(1));

        // Incremental edits after the swap stay in the shadow bank
        for (int k = 0; k < 100; k++) begin
            rand_write(1'b0);
            scan_en = 1'($urandom_range(0, 1));
            step();
        end
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
